sad_best_mv_tracker: RTL and testbench
======================================

// Module: sad_best_mv_tracker
// PURPOSE
//  Downstream of the per-partition SAD compare stage. Consumes one SAD vector per
//  candidate (4 x 16x16 lanes + 1 x 32x32) over a full-search window. Tracks minimum
//  SAD and its motion vector (MV) per partition. Reports the result with a done pulse
//  to the mode-decision stage.
// PARAMETERS
//  SR         16   search range; MV x,y span [-SR, SR-1]; 2*SR*2*SR candidates
//  ET_THRESH  256  early-termination SAD threshold (only used with ME_EARLY_TERM_EN)
//  MVW (local) $clog2(2*SR) = 5   signed bits per MV component
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  start          in   1       begin new search; sampled only in IDLE
//  sad_valid      in   1       SAD vector valid for current candidate
//  sad_ready      out  1       =1 only in SCAN; accept when sad_valid & sad_ready
//  sad16x16       in   64      4 lanes x 16b; lane l at [l*16 +: 16]
//  sad32x32       in   18      32x32 SAD
//  busy           out  1       high in SCAN
//  done           out  1       one-cycle pulse; best_* final and stable
//  best_sad16x16  out  64      minimum per 16x16 lane
//  best_mv16x16   out  4*2*MVW lane l at [l*2*MVW +: 2*MVW] = {mvy, mvx}, two's compl.
//  best_sad32x32  out  18      minimum 32x32 SAD
//  best_mv32x32   out  2*MVW   {mvy, mvx}
// BEHAVIOUR
//  Reset: busy=0, sad_ready=0, done=0, best_sad*=all ones, best_mv*=0, counters=0, FSM=IDLE.
//  FSM IDLE -> SCAN on start; SCAN -> DONE on last accept; DONE -> IDLE after 1 cycle.
//  start in SCAN/DONE ignored; sad_valid outside SCAN ignored (not consumed).
//  On start: best_sad* <= all ones, best_mv* <= 0, cand x=y=-SR.
//  Candidate order: raster; x inner (-SR..SR-1), y outer; advance once per accept only.
//  Per accept, per lane independently: if sad < best_sad (strict), update best_sad and
//   best_mv <= {y, x} of the current candidate. Ties keep the earlier candidate.
//  Update latency: 1 cycle (registered), visible the cycle after the accept.
//  Last candidate (x=y=SR-1): its compare is applied the same edge as SCAN->DONE.
//   done is high the next cycle with final values; sad_ready=0 from that cycle.
//  Counter compare uses explicit signed MVW-bit arithmetic; no wrap beyond SR-1.
//  best_* hold after done until next start (cleared then) or rst.
//  rst mid-SCAN: all reset values next cycle; partial results discarded.
//  Total accepts per full search = 4*SR*SR (1024 at default); valid gaps only stretch time.
// CONFIGURATION
//  ME_EARLY_TERM_EN defined:
//   - On an accept with sad32x32 < ET_THRESH, that compare is applied and the FSM goes
//     SCAN -> DONE on the same edge.
//   - Remaining candidates are not requested (sad_ready=0 from the next cycle).
//  ME_EARLY_TERM_EN undefined:
//   - Always full sweep; ET_THRESH unused; no threshold logic synthesised.
// TESTING
//  T1 Constant SAD 100 on all lanes, 1024 accepts:
//     -> all best_mv={-16,-16}, best_sad=100; done exactly 1 cycle after 1024th accept.
//  T2 Lane2 = 10 at (x=3, y=-5), else 200:
//     -> best_mv16x16 lane2={-5,3}, sad 10; other lanes {-16,-16}, sad 200.
//  T3 sad32x32 = 50 at (0,0) and (1,0), else 900:
//     -> best_mv32x32={0,0}, best_sad32x32=50 (tie keeps first).
//  T4 sad_valid toggles 1,0,0,1... with T2 data:
//     -> identical results; done only after 1024th accept; no double count.
//  T5 rst asserted after 500 accepts:
//     -> next cycle busy=0, best_sad=all ones, mv=0. A new start then runs a full,
//        uncontaminated search.
//  T6 [ME_EARLY_TERM_EN, ET_THRESH=64] sad32x32 = 10 at candidate #7 (x=-9, y=-16),
//     else 500:
//     -> done on the next cycle; best_mv32x32={-16,-9}; sad_ready=0 afterward.

Source files
------------

// File: rtl/sad_best_mv_tracker.sv
// Best-MV tracker: per-partition minimum SAD and its motion vector over a raster full search.
// Optional ME_EARLY_TERM_EN: end the scan on an accepted 32x32 SAD below ET_THRESH.
module sad_best_mv_tracker #(
   parameter  int SR        = 16,
   parameter  int ET_THRESH = 256,
   localparam int MVW       = $clog2(2*SR)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sad_valid,
   output logic               sad_ready,
   input  logic [63:0]        sad16x16,
   input  logic [17:0]        sad32x32,
   output logic               busy,
   output logic               done,
   output logic [63:0]        best_sad16x16,
   output logic [4*2*MVW-1:0] best_mv16x16,
   output logic [17:0]        best_sad32x32,
   output logic [2*MVW-1:0]   best_mv32x32
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic signed [MVW-1:0] MV_MIN = MVW'(-SR);
   localparam logic signed [MVW-1:0] MV_MAX = MVW'(SR - 1);
   localparam logic signed [MVW-1:0] MV_ONE = MVW'(1);

   state_t                state, state_nx;
   logic signed [MVW-1:0] cand_x, cand_y;
   logic                  accept, last_cand, et_hit;

   assign accept    = sad_valid && (state == SCAN);
   assign last_cand = (cand_x == MV_MAX) && (cand_y == MV_MAX);

`ifdef ME_EARLY_TERM_EN
   assign et_hit = accept && ({14'd0, sad32x32} < 32'(ET_THRESH));
`else
   logic unused_et_thresh;
   assign unused_et_thresh = ^ET_THRESH;
   assign et_hit           = 1'b0;
`endif

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      sad_ready = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nx = SCAN;
         SCAN: begin
            busy      = 1'b1;
            sad_ready = 1'b1;
            if (accept && (last_cand || et_hit)) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cand_x        <= '0;
         cand_y        <= '0;
         best_sad16x16 <= '1;
         best_mv16x16  <= '0;
         best_sad32x32 <= '1;
         best_mv32x32  <= '0;
      end else begin
         state <= state_nx;
         if ((state == IDLE) && start) begin
            cand_x        <= MV_MIN;
            cand_y        <= MV_MIN;
            best_sad16x16 <= '1;
            best_mv16x16  <= '0;
            best_sad32x32 <= '1;
            best_mv32x32  <= '0;
         end else if (accept) begin
            // strict compare: ties keep the earlier candidate
            for (int unsigned l = 0; l < 4; l++) begin
               if (sad16x16[l*16 +: 16] < best_sad16x16[l*16 +: 16]) begin
                  best_sad16x16[l*16 +: 16]      <= sad16x16[l*16 +: 16];
                  best_mv16x16[l*2*MVW +: 2*MVW] <= {cand_y, cand_x};
               end
            end
            if (sad32x32 < best_sad32x32) begin
               best_sad32x32 <= sad32x32;
               best_mv32x32  <= {cand_y, cand_x};
            end
            if (!last_cand) begin
               if (cand_x == MV_MAX) begin
                  cand_x <= MV_MIN;
                  cand_y <= cand_y + MV_ONE;
               end else begin
                  cand_x <= cand_x + MV_ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sad_best_mv_tracker.sv
// Bench for sad_best_mv_tracker: table of full searches plus reset-mid-scan sequence, checked
// against an argmin model over per-candidate SAD tables.
module tb_sad_best_mv_tracker;

   localparam int NCAND = 1024;
`ifdef ME_EARLY_TERM_EN
   localparam int ET = 64;
`else
   localparam int ET = 256;
`endif

   logic        clk = 1'b0;
   logic        rst, start, sad_valid, sad_ready, busy, done;
   logic [63:0] sad16x16, best_sad16x16;
   logic [17:0] sad32x32, best_sad32x32;
   logic [39:0] best_mv16x16;
   logic [9:0]  best_mv32x32;

   always #5 clk = ~clk;

   sad_best_mv_tracker #(.SR(16), .ET_THRESH(ET)) dut (
      .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid), .sad_ready(sad_ready),
      .sad16x16(sad16x16), .sad32x32(sad32x32), .busy(busy), .done(done),
      .best_sad16x16(best_sad16x16), .best_mv16x16(best_mv16x16),
      .best_sad32x32(best_sad32x32), .best_mv32x32(best_mv32x32)
   );

   logic [15:0] tab16 [NCAND][4];
   logic [17:0] tab32 [NCAND];
   logic [15:0] exp_sad16 [4];
   logic [9:0]  exp_mv16 [4];
   logic [17:0] exp_sad32;
   logic [9:0]  exp_mv32;
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      int          pat;
      int          gap;
      bit          fixed;
      logic [15:0] s0;
      logic [9:0]  m0;
      logic [15:0] s2;
      logic [9:0]  m2;
      logic [17:0] s32;
      logic [9:0]  m32;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] mv_of(input int k);
      logic [4:0] x, y;
      x = 5'(k % 32 - 16);
      y = 5'(k / 32 - 16);
      return {y, x};
   endfunction

   // min value over the first n candidates, then the earliest candidate holding it
   task automatic model(input int n);
      logic [17:0] m;
      for (int l = 0; l < 4; l++) begin
         m = 18'hFFFF;
         for (int k = 0; k < n; k++) if (18'(tab16[k][l]) < m) m = 18'(tab16[k][l]);
         exp_sad16[l] = m[15:0];
         exp_mv16[l]  = '0;
         if (m != 18'hFFFF)
            for (int k = n - 1; k >= 0; k--) if (18'(tab16[k][l]) == m) exp_mv16[l] = mv_of(k);
      end
      m = 18'h3FFFF;
      for (int k = 0; k < n; k++) if (tab32[k] < m) m = tab32[k];
      exp_sad32 = m;
      exp_mv32  = '0;
      if (m != 18'h3FFFF)
         for (int k = n - 1; k >= 0; k--) if (tab32[k] == m) exp_mv32 = mv_of(k);
   endtask

   function automatic int eff_len();
`ifdef ME_EARLY_TERM_EN
      for (int k = 0; k < NCAND; k++) if (tab32[k] < 18'(ET)) return k + 1;
`endif
      return NCAND;
   endfunction

   task automatic fill_pattern(input int pat);
      for (int k = 0; k < NCAND; k++) begin
         int x, y;
         x = k % 32 - 16;
         y = k / 32 - 16;
         for (int l = 0; l < 4; l++) tab16[k][l] = 16'd300;
         tab32[k] = 18'd300;
         case (pat)
            0: begin
               for (int l = 0; l < 4; l++) tab16[k][l] = 16'd100;
               tab32[k] = 18'd100;
            end
            1: begin
               for (int l = 0; l < 4; l++) tab16[k][l] = 16'd200;
               if (x == 3 && y == -5) tab16[k][2] = 16'd10;
               tab32[k] = 18'd200;
            end
            2: tab32[k] = (y == 0 && (x == 0 || x == 1)) ? 18'd50 : 18'd900;
            3: begin
               for (int l = 0; l < 4; l++) tab16[k][l] = 16'($urandom_range(0, 40));
               tab32[k] = 18'($urandom_range(0, 40));
            end
            4: begin
               tab16[k][0] = 16'hFFFF;
               tab16[k][1] = 16'($urandom);
               tab16[k][2] = (k == NCAND - 1) ? 16'd0 : 16'd5;
               tab16[k][3] = 16'($urandom);
               tab32[k]    = 18'h3FFFF;
            end
            default: tab32[k] = (k == 7) ? 18'd10 : 18'd500;
         endcase
      end
   endtask

   task automatic check_best(input string tag);
      for (int l = 0; l < 4; l++) begin
         chk($sformatf("%s sad16[%0d]", tag, l), 64'(best_sad16x16[l*16 +: 16]), 64'(exp_sad16[l]));
         chk($sformatf("%s mv16[%0d]", tag, l), 64'(best_mv16x16[l*10 +: 10]), 64'(exp_mv16[l]));
      end
      chk({tag, " sad32"}, 64'(best_sad32x32), 64'(exp_sad32));
      chk({tag, " mv32"}, 64'(best_mv32x32), 64'(exp_mv32));
   endtask

   task automatic run_search(input int gap, input int n_acc, input bit full, input string tag);
      int acc, cyc;
      bit v, take, early;
      acc = 0; cyc = 0; early = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (acc < n_acc && cyc < 8000) begin
         case (gap)
            0:       v = 1'b1;
            1:       v = (cyc % 3 == 0);
            default: v = ($urandom_range(0, 1) == 1);
         endcase
         sad_valid = v;
         if (v) begin
            sad16x16 = {tab16[acc][3], tab16[acc][2], tab16[acc][1], tab16[acc][0]};
            sad32x32 = tab32[acc];
         end else begin
            sad16x16 = {$urandom, $urandom};
            sad32x32 = 18'($urandom);
         end
         if (gap == 2) start = ($urandom_range(0, 7) == 0);
         take = v && sad_ready;
         @(posedge clk); #1;
         cyc++;
         if (take) acc++;
         if (done && acc < n_acc) early = 1'b1;
         if (take && acc == 300) begin
            model(300);
            check_best({tag, " mid"});
            chk({tag, " busy mid"}, 64'(busy), 64'd1);
         end
      end
      sad_valid = 1'b0;
      start     = 1'b0;
      chk({tag, " accepts"}, 64'(acc), 64'(n_acc));
      chk({tag, " early done"}, 64'(early), 64'd0);
      if (full) begin
         chk({tag, " done"}, 64'(done), 64'd1);
         chk({tag, " busy at done"}, 64'(busy), 64'd0);
         chk({tag, " ready at done"}, 64'(sad_ready), 64'd0);
         model(n_acc);
         check_best(tag);
         // zero SADs offered outside SCAN must not be consumed
         sad_valid = 1'b1;
         sad16x16  = '0;
         sad32x32  = '0;
         @(posedge clk); #1;
         sad_valid = 1'b0;
         chk({tag, " done pulse"}, 64'(done), 64'd0);
         check_best({tag, " hold"});
      end
   endtask

   initial begin
      vecs[0] = '{"T1",   0, 0, 1'b1, 16'd100,   10'h210, 16'd100, 10'h210, 18'd100,     10'h210};
      vecs[1] = '{"T2",   1, 0, 1'b1, 16'd200,   10'h210, 16'd10,  10'h363, 18'd200,     10'h210};
      vecs[2] = '{"T3",   2, 0, 1'b1, 16'd300,   10'h210, 16'd300, 10'h210, 18'd50,      10'h000};
      vecs[3] = '{"T4",   1, 1, 1'b1, 16'd200,   10'h210, 16'd10,  10'h363, 18'd200,     10'h210};
      vecs[4] = '{"T6",   5, 0, 1'b1, 16'd300,   10'h210, 16'd300, 10'h210, 18'd10,      10'h217};
      vecs[5] = '{"EDGE", 4, 2, 1'b1, 16'hFFFF,  10'h000, 16'd0,   10'h1EF, 18'h3FFFF,   10'h000};
      vecs[6] = '{"RND1", 3, 2, 1'b0, 16'd0,     10'h000, 16'd0,   10'h000, 18'd0,       10'h000};
      vecs[7] = '{"RND2", 3, 0, 1'b0, 16'd0,     10'h000, 16'd0,   10'h000, 18'd0,       10'h000};

      rst = 1'b1; start = 1'b0; sad_valid = 1'b0; sad16x16 = '0; sad32x32 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset ready", 64'(sad_ready), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset sad16", best_sad16x16, '1);
      chk("reset sad32", 64'(best_sad32x32), 64'h3FFFF);
      chk("reset mv16", 64'(best_mv16x16), 64'd0);
      chk("reset mv32", 64'(best_mv32x32), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         int n;
         fill_pattern(vecs[i].pat);
         n = eff_len();
         run_search(vecs[i].gap, n, 1'b1, vecs[i].name);
         if (vecs[i].fixed && (n == NCAND || vecs[i].pat == 5)) begin
            chk({vecs[i].name, " tbl sad0"}, 64'(best_sad16x16[15:0]), 64'(vecs[i].s0));
            chk({vecs[i].name, " tbl mv0"}, 64'(best_mv16x16[9:0]), 64'(vecs[i].m0));
            chk({vecs[i].name, " tbl sad2"}, 64'(best_sad16x16[47:32]), 64'(vecs[i].s2));
            chk({vecs[i].name, " tbl mv2"}, 64'(best_mv16x16[29:20]), 64'(vecs[i].m2));
            chk({vecs[i].name, " tbl sad32"}, 64'(best_sad32x32), 64'(vecs[i].s32));
            chk({vecs[i].name, " tbl mv32"}, 64'(best_mv32x32), 64'(vecs[i].m32));
         end
      end

      // reset in the middle of a scan, then a fresh search
      fill_pattern(1);
      run_search(0, 500, 1'b0, "T5pre");
      rst = 1'b1;
      @(posedge clk); #1;
      chk("T5 busy", 64'(busy), 64'd0);
      chk("T5 ready", 64'(sad_ready), 64'd0);
      chk("T5 done", 64'(done), 64'd0);
      chk("T5 sad16", best_sad16x16, '1);
      chk("T5 sad32", 64'(best_sad32x32), 64'h3FFFF);
      chk("T5 mv16", 64'(best_mv16x16), 64'd0);
      chk("T5 mv32", 64'(best_mv32x32), 64'd0);
      rst = 1'b0;
      fill_pattern(2);
      run_search(0, eff_len(), 1'b1, "T5post");
      chk("T5post lane2 sad", 64'(best_sad16x16[47:32]), 64'd300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
